// File: rtl/vga_sync_decoder_pkg.sv
// ============================================================================
//  Module      : vga_sync_decoder_pkg
//  Description : Shared VGA 640x480@60 timing constants, the 10-bit counter
//                type and the decoder FSM state encoding. The timing
//                constants are also used by the sync generator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_sync_decoder_pkg;

    // Horizontal timing in pixel clocks
    localparam int c_H_VISIBLE = 640;
    localparam int c_H_FRONT   = 16;
    localparam int c_H_SYNC    = 96;
    localparam int c_H_BACK    = 48;
    localparam int c_H_TOTAL   = c_H_VISIBLE + c_H_FRONT + c_H_SYNC + c_H_BACK;  // 800

    // Vertical timing in lines
    localparam int c_V_VISIBLE = 480;
    localparam int c_V_FRONT   = 10;
    localparam int c_V_SYNC    = 2;
    localparam int c_V_BACK    = 33;
    localparam int c_V_TOTAL   = c_V_VISIBLE + c_V_FRONT + c_V_SYNC + c_V_BACK;  // 525

    // All position / measurement counters are 10 bits wide
    typedef logic [9:0] cnt_t;

    // Decoder FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_ST_SEARCH  = 2'd0;
    localparam state_t c_ST_MEASURE = 2'd1;
    localparam state_t c_ST_LOCKED  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/vga_edge_detect.sv
// ============================================================================
//  Module      : vga_edge_detect
//  Description : Two-stage input register (s1, s2) with edge outputs derived
//                by comparing s1 against s2.
//  Ports       : i_clk  - clock
//                i_rst  - synchronous active-high reset
//                i_d    - raw input pin
//                o_q    - stage-1 registered copy of i_d
//                o_rise - s1 high, s2 low
//                o_fall - s1 low, s2 high
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q    = r_s1;
    assign o_rise = r_s1 & ~r_s2;
    assign o_fall = ~r_s1 & r_s2;

endmodule

`default_nettype wire

// File: rtl/vga_sync_decoder.sv
// ============================================================================
//  Module      : vga_sync_decoder
//  Description : Recovers pixel position from VGA sync/blank inputs, measures
//                line width and frame height, and locks once LOCK_FRAMES
//                consecutive frames match the expected timing.
//  Ports       : i_clk, i_rst                - pixel clock, sync active-high reset
//                i_hsync_n, i_vsync_n        - active-low sync pulses
//                i_hblank_n, i_vblank_n      - blanking, low = blanked
//                o_x, o_y                    - visible column / row
//                o_active                    - pixel visible
//                o_line_start, o_frame_start - hsync / vsync falling-edge pulses
//                o_locked                    - timing matches parameters
//                o_err                       - one-cycle violation pulse while locked
//                o_line_width, o_frame_height- last measured values
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_decoder
    import vga_sync_decoder_pkg::*;
#(
    parameter int LINE_WIDTH   = c_H_TOTAL,
    parameter int FRAME_HEIGHT = c_V_TOTAL,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_hsync_n,
    input  logic       i_vsync_n,
    input  logic       i_hblank_n,
    input  logic       i_vblank_n,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_active,
    output logic       o_line_start,
    output logic       o_frame_start,
    output logic       o_locked,
    output logic       o_err,
    output logic [9:0] o_line_width,
    output logic [9:0] o_frame_height
);

    localparam cnt_t c_LINE_W   = cnt_t'(LINE_WIDTH);
    localparam cnt_t c_FRAME_H  = cnt_t'(FRAME_HEIGHT);
    localparam cnt_t c_CNT_MAX  = '1;
    localparam int   c_GOOD_W   = $clog2(LOCK_FRAMES + 1);
    localparam logic [c_GOOD_W-1:0] c_GOOD_LAST = c_GOOD_W'(LOCK_FRAMES - 1);
    localparam logic [c_GOOD_W-1:0] c_GOOD_FULL = c_GOOD_W'(LOCK_FRAMES);

    // Bit positions of each input in the edge-detector vectors
    localparam int c_HS = 3;
    localparam int c_VS = 2;
    localparam int c_HB = 1;
    localparam int c_VB = 0;

    logic [3:0] w_pin;
    logic [3:0] w_q;
    logic [3:0] w_rise;
    logic [3:0] w_fall;

    assign w_pin = {i_hsync_n, i_vsync_n, i_hblank_n, i_vblank_n};

    for (genvar gi = 0; gi < 4; gi++) begin : g_edge
        vga_edge_detect u_edge (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_d    (w_pin[gi]),
            .o_q    (w_q[gi]),
            .o_rise (w_rise[gi]),
            .o_fall (w_fall[gi])
        );
    end

    // Edge/level bits this block has no use for
    logic w_unused;
    assign w_unused = ^{w_q[c_HS], w_q[c_VS], w_rise[c_HS], w_rise[c_VS],
                        w_fall[c_HB], w_fall[c_VB]};

    logic w_hs_fall;
    logic w_vs_fall;
    logic w_hb_rise;
    logic w_vb_rise;
    logic w_vis_s1;

    assign w_hs_fall = w_fall[c_HS];
    assign w_vs_fall = w_fall[c_VS];
    assign w_hb_rise = w_rise[c_HB];
    assign w_vb_rise = w_rise[c_VB];
    assign w_vis_s1  = w_q[c_HB] & w_q[c_VB];

    // ------------------------------------------------------------------------
    // Line / frame measurement and pixel position
    // ------------------------------------------------------------------------
    cnt_t r_h_cnt;
    cnt_t r_v_cnt;
    cnt_t w_h_cnt_p1;
    cnt_t w_v_cnt_p1;
    logic r_y_pend;     // vblank ended; next hblank rise is row 0

    assign w_h_cnt_p1 = r_h_cnt + 10'd1;
    assign w_v_cnt_p1 = r_v_cnt + 10'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h_cnt        <= '0;
            r_v_cnt        <= '0;
            r_y_pend       <= 1'b0;
            o_x            <= '0;
            o_y            <= '0;
            o_active       <= 1'b0;
            o_line_start   <= 1'b0;
            o_frame_start  <= 1'b0;
            o_line_width   <= '0;
            o_frame_height <= '0;
        end else begin
            o_line_start  <= w_hs_fall;
            o_frame_start <= w_vs_fall;
            o_active      <= w_vis_s1;

            if (w_hs_fall) begin
                r_h_cnt      <= '0;
                o_line_width <= w_h_cnt_p1;
                // Frame boundary only when vsync falls on the same cycle
                r_v_cnt      <= w_vs_fall ? '0 : w_v_cnt_p1;
            end else if (r_h_cnt != c_CNT_MAX) begin
                r_h_cnt <= w_h_cnt_p1;
            end

            if (w_vs_fall) begin
                o_frame_height <= w_v_cnt_p1;
            end

            if (w_hb_rise) begin
                o_x <= '0;
            end else if (w_vis_s1) begin
                o_x <= o_x + 10'd1;
            end

            // vblank and hblank normally rise together at the top of the
            // frame, so a coincident vblank rise also restarts the row count.
            if (w_hb_rise) begin
                o_y      <= (r_y_pend || w_vb_rise) ? '0 : o_y + 10'd1;
                r_y_pend <= 1'b0;
            end else if (w_vb_rise) begin
                r_y_pend <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [c_GOOD_W-1:0] r_good;
    logic                r_line_err;
    logic                w_line_bad;
    logic                w_height_ok;
    logic                w_viol;

    assign w_line_bad  = w_hs_fall && (w_h_cnt_p1 != c_LINE_W);
    assign w_height_ok = (w_v_cnt_p1 == c_FRAME_H);
    assign w_viol      = w_line_bad
                       || (w_vs_fall && !w_height_ok)
                       || (w_vs_fall && !w_hs_fall)
                       || (r_h_cnt == c_CNT_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= c_ST_SEARCH;
            r_good     <= '0;
            r_line_err <= 1'b0;
            o_locked   <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_err <= 1'b0;
            case (r_state)
                c_ST_SEARCH: begin
                    if (w_vs_fall) begin
                        r_state    <= c_ST_MEASURE;
                        r_good     <= '0;
                        r_line_err <= 1'b0;
                    end
                end
                c_ST_MEASURE: begin
                    if (w_vs_fall) begin
                        // A bad line ending on this very edge belongs to the
                        // frame being judged, so it is folded in here.
                        r_line_err <= 1'b0;
                        if (w_height_ok && !r_line_err && !w_line_bad) begin
                            if (r_good == c_GOOD_LAST) begin
                                r_good  <= c_GOOD_FULL;
                                r_state <= c_ST_LOCKED;
                            end else begin
                                r_good <= r_good + 1'b1;
                            end
                        end else begin
                            r_good <= '0;
                        end
                    end else if (w_line_bad) begin
                        r_line_err <= 1'b1;
                    end
                end
                c_ST_LOCKED: begin
                    if (w_viol) begin
                        r_state <= c_ST_SEARCH;
                        o_err   <= 1'b1;
                    end
                end
                default: r_state <= c_ST_SEARCH;
            endcase
            o_locked <= (r_state == c_ST_LOCKED) && !w_viol;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
// ============================================================================
//  Module      : tb_vga_sync_decoder
//  Description : Self-checking bench for vga_sync_decoder using a reduced
//                40x30 raster (32x24 visible). Expected pixel state is queued
//                as pins are driven and compared two clocks later; lock/error
//                behaviour is checked per scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_decoder;

    localparam int HV  = 32;
    localparam int HFP = 2;
    localparam int HS  = 4;
    localparam int HT  = 40;
    localparam int VV  = 24;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VT  = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       hs_n, vs_n, hb_n, vb_n;
    logic [9:0] o_x, o_y, o_line_width, o_frame_height;
    logic       o_active, o_line_start, o_frame_start, o_locked, o_err;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .LINE_WIDTH   (HT),
        .FRAME_HEIGHT (VT),
        .LOCK_FRAMES  (2)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_hsync_n      (hs_n),
        .i_vsync_n      (vs_n),
        .i_hblank_n     (hb_n),
        .i_vblank_n     (vb_n),
        .o_x            (o_x),
        .o_y            (o_y),
        .o_active       (o_active),
        .o_line_start   (o_line_start),
        .o_frame_start  (o_frame_start),
        .o_locked       (o_locked),
        .o_err          (o_err),
        .o_line_width   (o_line_width),
        .o_frame_height (o_frame_height)
    );

    typedef struct {
        bit chk;
        bit act;
        bit xy;
        int x;
        int y;
    } exp_t;

    exp_t q[$];

    int n_vec = 0;
    int n_miscmp = 0;
    int cyc = 0;
    int n_fs, n_err, fs_cyc, err_cyc, ls_cyc, lock_fs, lock_dly;
    int win_act, first_x, first_y, last_x, last_y;
    bit err_lock, prev_locked, chk_zero, xy_ok;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_mon();
        n_fs     = 0;
        n_err    = 0;
        fs_cyc   = 0;
        err_cyc  = 0;
        lock_fs  = -1;
        lock_dly = -1;
        err_lock = 1'b1;
    endtask

    // One pixel clock: sample outputs, retire the oldest expectation, drive pins.
    task automatic tick(input bit r, input logic hs, input logic vs, input logic hb,
                        input logic vb, input int x, input int y);
        exp_t e;
        @(negedge clk);
        cyc++;
        if (o_line_start === 1'b1) ls_cyc = cyc;
        if (o_frame_start === 1'b1) begin n_fs++; fs_cyc = cyc; end
        if (o_err === 1'b1) begin n_err++; err_cyc = cyc; err_lock = o_locked; end
        if (o_locked === 1'b1 && !prev_locked) begin
            lock_fs  = n_fs;
            lock_dly = cyc - fs_cyc;
        end
        prev_locked = (o_locked === 1'b1);
        if (o_active === 1'b1) begin
            if (win_act == 0) begin first_x = int'(o_x); first_y = int'(o_y); end
            last_x = int'(o_x);
            last_y = int'(o_y);
            win_act++;
        end
        if (chk_zero)
            chk("rst_outputs", 64'({o_x, o_y, o_active, o_line_start, o_frame_start,
                                    o_locked, o_err, o_line_width, o_frame_height}), 64'd0);
        chk_zero = r;
        if (q.size() == 2) begin
            e = q.pop_front();
            if (e.chk) begin
                chk("active", 64'(o_active), 64'(e.act));
                if (e.xy) begin
                    chk("x", 64'(o_x), 64'(e.x));
                    chk("y", 64'(o_y), 64'(e.y));
                end
            end
        end
        if (r) begin
            q.delete();
            xy_ok = 1'b0;
            clear_mon();
        end
        if (!r && hb && vb && x == 0 && y == 0) xy_ok = 1'b1;
        rst  = r;
        hs_n = hs;
        vs_n = vs;
        hb_n = hb;
        vb_n = vb;
        e.chk = !r;
        e.act = hb & vb;
        e.xy  = xy_ok && hb && vb;
        e.x   = x;
        e.y   = y;
        q.push_back(e);
    endtask

    function automatic logic vs_pin(input int ln, input int h, input int sh);
        int k;
        int s;
        k = ln * HT + h;
        s = (VV + VFP) * HT + HV + HFP + sh;
        return !(k >= s && k < s + VS * HT);
    endfunction

    task automatic run_frame(input int short_ln, input int vs_shift,
                             input int rst_ln, input int rst_px);
        for (int ln = 0; ln < VT; ln++) begin
            for (int h = 0; h < HT; h++) begin
                if (!(ln == short_ln && h == HT - 1)) begin
                    tick(ln == rst_ln && h == rst_px,
                         !(h >= HV + HFP && h < HV + HFP + HS),
                         vs_pin(ln, h, vs_shift),
                         h < HV, ln < VV, h, ln);
                end
            end
        end
    endtask

    task automatic idle(input int n, input bit r);
        repeat (n) tick(r, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; hs_n = 1'b1; vs_n = 1'b1; hb_n = 1'b0; vb_n = 1'b0;
        prev_locked = 1'b0; chk_zero = 1'b0; xy_ok = 1'b0; win_act = 0;
        ls_cyc = 0; first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        clear_mon();
        idle(3, 1'b1);

        // Ideal raster from reset: lock one cycle after the 3rd frame start
        repeat (4) run_frame(-1, 0, -1, -1);
        chk("ideal_lock_fs",   64'(lock_fs), 64'(3));
        chk("ideal_lock_dly",  64'(lock_dly), 64'(1));
        chk("ideal_err",       64'(n_err), 64'(0));
        chk("ideal_locked",    64'(o_locked), 64'(1));
        chk("line_width",      64'(o_line_width), 64'(HT));
        chk("frame_height",    64'(o_frame_height), 64'(VT));

        // One locked frame: active count and first/last pixel
        win_act = 0;
        run_frame(-1, 0, -1, -1);
        chk("active_count", 64'(win_act), 64'(HV * VV));
        chk("first_x", 64'(first_x), 64'(0));
        chk("first_y", 64'(first_y), 64'(0));
        chk("last_x",  64'(last_x), 64'(HV - 1));
        chk("last_y",  64'(last_y), 64'(VV - 1));
        chk("frame_locked", 64'(o_locked), 64'(1));

        // Short line while locked, then relock after two good frames
        clear_mon();
        run_frame(5, 0, -1, -1);
        chk("short_err",       64'(n_err), 64'(1));
        chk("short_err_lock",  64'(err_lock), 64'(0));
        chk("short_unlocked",  64'(o_locked), 64'(0));
        repeat (2) run_frame(-1, 0, -1, -1);
        chk("short_relock_fs", 64'(lock_fs), 64'(3));
        chk("short_relock_dly",64'(lock_dly), 64'(1));
        chk("short_relocked",  64'(o_locked), 64'(1));
        chk("short_err_once",  64'(n_err), 64'(1));

        // hsync stuck high: timeout 1024 clocks after the last line start
        clear_mon();
        idle(1100, 1'b0);
        chk("timeout_err",     64'(n_err), 64'(1));
        chk("timeout_delay",   64'(err_cyc - ls_cyc), 64'(1024));
        chk("timeout_err_lock",64'(err_lock), 64'(0));
        chk("timeout_unlocked",64'(o_locked), 64'(0));
        repeat (3) run_frame(-1, 0, -1, -1);
        chk("timeout_relock_fs", 64'(lock_fs), 64'(3));
        chk("timeout_relocked",  64'(o_locked), 64'(1));

        // One-cycle reset mid-frame: all outputs clear, relock from scratch
        run_frame(-1, 0, 20, 15);
        repeat (2) run_frame(-1, 0, -1, -1);
        chk("rst_relock_fs",  64'(lock_fs), 64'(3));
        chk("rst_relock_dly", 64'(lock_dly), 64'(1));
        chk("rst_err",        64'(n_err), 64'(0));
        chk("rst_relocked",   64'(o_locked), 64'(1));

        // vsync fall 5 clocks after hsync fall while locked
        clear_mon();
        run_frame(-1, 5, -1, -1);
        chk("shift_err",      64'(n_err), 64'(1));
        chk("shift_err_lock", 64'(err_lock), 64'(0));
        chk("shift_unlocked", 64'(o_locked), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameter LINE_WIDTH, default 800, is the expected pixel clocks per line.
REQ-002 Parameter FRAME_HEIGHT, default 525, is the expected lines per frame.
REQ-003 Parameter LOCK_FRAMES, default 2, is the number of consecutive good frames required to lock.
REQ-004 i_clk  in  1  pixel clock; the block SHALL use this single clock domain only.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_hsync_n / i_vsync_n  in  1 each  sync pulses, active-low.
REQ-007 i_hblank_n / i_vblank_n  in  1 each  blanking, low = blanked.
REQ-008 o_x  out  10  visible column, 0..639.
REQ-009 o_y  out  10  visible row, 0..479.
REQ-010 o_active  out  1  high while the pixel is visible (hblank_n & vblank_n).
REQ-011 o_line_start / o_frame_start  out  1 each  one-cycle pulses on hsync / vsync falling edges.
REQ-012 o_locked  out  1  timing matches the parameters.
REQ-013 o_err  out  1  one-cycle pulse on a timing violation.
REQ-014 o_line_width / o_frame_height  out  10 each  last measured values.

Function
REQ-015 The block SHALL register all four inputs in stage s1, then again in stage s2. Edges SHALL be detected by comparing s1 with s2.
REQ-016 All outputs SHALL be registered. o_active, o_x and o_y SHALL lag the input pins by exactly 2 clocks.
REQ-017 h_cnt SHALL load 0 on an hsync falling edge. Otherwise it SHALL increment, saturating at 1023.
REQ-018 On an hsync falling edge, o_line_width SHALL capture h_cnt+1, and o_line_start SHALL pulse.
REQ-019 v_cnt SHALL increment on each hsync falling edge. It SHALL load 0 when the vsync falling edge coincides with that hsync edge.
REQ-020 On a vsync falling edge, o_frame_height SHALL capture v_cnt+1, and o_frame_start SHALL pulse.
REQ-021 o_x SHALL load 0 on an hblank_n rising edge and SHALL increment on each subsequent active cycle.
REQ-022 o_y SHALL load 0 on the first hblank_n rising edge after a vblank_n rising edge, and SHALL increment on each later hblank_n rising edge.
REQ-023 FSM states SHALL be SEARCH, MEASURE and LOCKED. A good-frame counter SHALL count 0..LOCK_FRAMES.
REQ-024 SEARCH SHALL go to MEASURE on a vsync falling edge, clearing the good-frame counter and the line-error flag.
REQ-025 In MEASURE, any captured line width other than LINE_WIDTH SHALL set the line-error flag.
REQ-026 In MEASURE, at each vsync falling edge:
- if the frame height equals FRAME_HEIGHT and the line-error flag is clear, the good-frame counter SHALL increment;
- otherwise the counter and flag SHALL clear.
REQ-027 When the good-frame counter reaches LOCK_FRAMES, the FSM SHALL go to LOCKED and o_locked SHALL assert on the following cycle.
REQ-028 In LOCKED, the following SHALL be violations:
- a line width not equal to LINE_WIDTH;
- a frame height not equal to FRAME_HEIGHT;
- h_cnt reaching 1023 (hsync timeout);
- a vsync falling edge without a coincident hsync falling edge.
REQ-029 On a violation in LOCKED, o_err SHALL pulse for 1 cycle, o_locked SHALL deassert, and the FSM SHALL go to SEARCH.
REQ-030 A violation outside LOCKED SHALL NOT pulse o_err.
REQ-031 o_x and o_y SHALL keep counting regardless of lock state. Consumers SHALL qualify them with o_locked.

Reset
REQ-032 While i_rst is high, on the next i_clk edge:
- the FSM SHALL enter SEARCH;
- all counters, flags and s1/s2 SHALL become 0;
- all outputs SHALL become 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame. Lock SHALL need a fresh vsync edge plus LOCK_FRAMES good frames.

Structure
REQ-034 A shared package SHALL hold the FSM state enum and the VGA 640x480 timing constants: visible sizes, porches, sync widths, 800 and 525. These constants SHALL be shared with the sync generator.
REQ-035 One sub-module, vga_edge_detect (2-stage register with rise/fall outputs), SHALL be instantiated per input.

Verification
REQ-036 Ideal 800x525 stimulus from reset: o_locked SHALL rise exactly 1 cycle after the 3rd vsync fall (1 search edge + 2 good frames), and o_err SHALL stay 0.
REQ-037 Locked, one frame observed: o_active SHALL be high for 307200 cycles. The first active cycle SHALL have o_x=0, o_y=0. The last SHALL have o_x=639, o_y=479.
REQ-038 Locked, one line shortened to 799 clocks: o_err SHALL pulse once, o_locked SHALL drop, and o_locked SHALL reassert after 2 further good frames.
REQ-039 Locked, i_hsync_n held high for 1100 cycles: o_err SHALL pulse when h_cnt hits 1023, and the FSM SHALL be in SEARCH.
REQ-040 i_rst pulsed for 1 cycle at line 200, pixel 300: every output SHALL be 0 on the next cycle, and relock SHALL follow the REQ-036 timing.
REQ-041 Locked, a vsync fall shifted by 5 clocks from the hsync fall: o_err SHALL pulse and o_locked SHALL be 0.
